// File: rtl/input_irq_ctrl.sv
// input_irq_ctrl: user-input interrupt controller.
// Each channel is synchronised, debounced and edge-detected into a sticky
// write-1-to-clear PENDING bit. The bits are masked and OR-reduced into one
// registered level interrupt. A small Avalon-MM slave with a fixed read
// latency of 1 exposes the register file.
module input_irq_ctrl #(
    parameter int N_IN            = 6,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N_IN-1:0] in_sig,
    input  logic [2:0]      avl_address,
    input  logic            avl_read,
    input  logic            avl_write,
    input  logic [31:0]     avl_writedata,
    output logic [31:0]     avl_readdata,
    output logic            avl_irq
);

    // A zero-cycle debounce still needs a legal counter width. In that case
    // the counters are never incremented.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (DEBOUNCE_CYCLES > 0) ? CNT_W'(DEBOUNCE_CYCLES - 1) : '0;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_PENDING = 3'd1;
    localparam logic [2:0] ADDR_MASK    = 3'd2;
    localparam logic [2:0] ADDR_RISE_EN = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN = 3'd4;

    // Synchroniser chain. Element [SYNC_STAGES-1] is the oldest stage.
    logic [SYNC_STAGES-1:0][N_IN-1:0] sync_p;
    logic [N_IN-1:0]                  sync_s;

    // Debounced state and per-channel stability counters.
    logic [N_IN-1:0]  db_q;
    logic [N_IN-1:0]  db_d;
    logic [CNT_W-1:0] cnt_q [N_IN];
    logic [CNT_W-1:0] cnt_d [N_IN];

    // Register file.
    logic [N_IN-1:0] pending_q;
    logic [N_IN-1:0] mask_q;
    logic [N_IN-1:0] rise_en_q;
    logic [N_IN-1:0] fall_en_q;

    logic [N_IN-1:0] edge_det;
    logic [N_IN-1:0] pend_clr;
    logic [31:0]     rd_mux;

    assign sync_s = sync_p[SYNC_STAGES-1];

    // Shift the raw inputs through the synchroniser flops.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], in_sig};
        end
    end

    // Debounce rule: the state follows the input only after DEBOUNCE_CYCLES
    // consecutive mismatching cycles. Any return to the held state restarts
    // the count.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < N_IN; i++) begin
            cnt_d[i] = '0;
        end
        if (DEBOUNCE_CYCLES == 0) begin
            db_d = sync_s;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (sync_s[i] != db_q[i]) begin
                    if (cnt_q[i] == CNT_LAST) begin
                        db_d[i] = sync_s[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Register the debounced state and the counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            db_q <= '0;
            for (int i = 0; i < N_IN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            db_q <= db_d;
            for (int i = 0; i < N_IN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Detect edges on the clock where the debounced state changes. Also
    // decode the W1C clear mask.
    always_comb begin
        edge_det = (db_d & ~db_q & rise_en_q) | (~db_d & db_q & fall_en_q);
        pend_clr = '0;
        if (avl_write && (avl_address == ADDR_PENDING)) begin
            pend_clr = avl_writedata[N_IN-1:0];
        end
    end

    // Update the sticky pending bits. A new edge wins over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~pend_clr) | edge_det;
        end
    end

    // Write the software-configurable control registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mask_q    <= '0;
            rise_en_q <= '1;
            fall_en_q <= '1;
        end else if (avl_write) begin
            case (avl_address)
                ADDR_MASK:    mask_q    <= avl_writedata[N_IN-1:0];
                ADDR_RISE_EN: rise_en_q <= avl_writedata[N_IN-1:0];
                ADDR_FALL_EN: fall_en_q <= avl_writedata[N_IN-1:0];
                default:      ;
            endcase
        end
    end

    // Select the read data from the pre-update register contents. Unused
    // upper bits and unmapped addresses read as zero.
    always_comb begin
        rd_mux = '0;
        case (avl_address)
            ADDR_DATA:    rd_mux[N_IN-1:0] = db_q;
            ADDR_PENDING: rd_mux[N_IN-1:0] = pending_q;
            ADDR_MASK:    rd_mux[N_IN-1:0] = mask_q;
            ADDR_RISE_EN: rd_mux[N_IN-1:0] = rise_en_q;
            ADDR_FALL_EN: rd_mux[N_IN-1:0] = fall_en_q;
            default:      rd_mux = '0;
        endcase
    end

    // Capture read data on a read strobe and hold it otherwise.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            avl_readdata <= '0;
        end else if (avl_read) begin
            avl_readdata <= rd_mux;
        end
    end

    // Register the interrupt level from the enabled pending bits.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            avl_irq <= 1'b0;
        end else begin
            avl_irq <= |(pending_q & mask_q);
        end
    end

endmodule

// File: doc/input_irq_ctrl.md
Name: input_irq_ctrl

Overview:
Parametrised user-input interrupt controller for keys, switches and general status lines on the HPS lightweight bus. Per channel it provides:
- input synchronisation
- debounce filtering
- per-edge detection (rising/falling enables)
- sticky pending bits with write-1-to-clear
- an interrupt mask

It presents a small Avalon-MM slave with fixed read latency 1 and one level interrupt to the HPS GIC.

Parameters:
N_IN, 6, number of input channels (1..32); mapped to register bits [N_IN-1:0].
SYNC_STAGES, 2, synchroniser flops per input (>=2).
DEBOUNCE_CYCLES, 1000, consecutive stable cycles required before the debounced state changes. 0 = debounce bypassed.

Ports:
clk  in  1  system clock, sole clock domain.
reset_n  in  1  synchronous, active-low reset.
in_sig  in  N_IN  asynchronous raw inputs (keys/switches/status).
avl_address  in  3  word address.
avl_read  in  1  read strobe.
avl_write  in  1  write strobe.
avl_writedata  in  32  write data.
avl_readdata  out  32  read data, valid the cycle after avl_read.
avl_irq  out  1  level interrupt, registered.

Behaviour:
- Reset (sampled on clk when reset_n=0) clears or presets all state:
  - sync chains, debounced state, debounce counters, PENDING, IRQ_MASK = 0
  - RISE_EN, FALL_EN = all ones on [N_IN-1:0]
  - avl_readdata = 0, avl_irq = 0
- Reset asserted mid-debounce or with pending set discards all state; no edge is reported for the reset itself.
- Synchroniser: in_sig passes through SYNC_STAGES flops; its last stage is s[i].
- Debounce, per channel:
  - If s[i]==db[i], cnt[i]<=0.
  - Else if cnt[i]==DEBOUNCE_CYCLES-1: db[i]<=s[i] and cnt[i]<=0.
  - Else cnt[i]<=cnt[i]+1.
  - So db changes after exactly DEBOUNCE_CYCLES consecutive mismatching cycles; any glitch back to db restarts the count.
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - DEBOUNCE_CYCLES=0: db<=s every cycle.
- Edge detect, per channel:
  - rise[i] = db_next[i] & ~db[i] & RISE_EN[i]
  - fall[i] = ~db_next[i] & db[i] & FALL_EN[i]
  - edge[i] = rise[i] | fall[i] sets PENDING[i] on the same clock db updates.
- Because db resets to 0, an input held high through reset produces one rising edge after debounce. This is intended: software sees initial state.
- Register map (avl_address):
  - 0 DATA: RO, db state. Writes ignored.
  - 1 PENDING: RO-sticky; a read does NOT clear. Write: bits with writedata=1 clear. If a clear and a new edge hit the same bit in the same cycle, set wins.
  - 2 IRQ_MASK: RW, 1 = enabled.
  - 3 RISE_EN: RW.
  - 4 FALL_EN: RW.
  - 5..7: read 0, writes ignored.
- Bits [31:N_IN] read 0 and ignore writes.
- Read: avl_readdata registered on the clock where avl_read=1, reflecting register contents before any same-cycle write or edge update. Otherwise avl_readdata holds its last value.
- avl_read and avl_write both high: both performed; read returns the pre-write value.
- avl_irq <= |(PENDING & IRQ_MASK), one cycle after PENDING/IRQ_MASK change.
- Mask changes take effect the following cycle. Masking does not clear PENDING; unmasking a pending bit raises avl_irq.
- Latency pin->avl_irq: SYNC_STAGES + DEBOUNCE_CYCLES + 1 clocks after the first clock sampling the new level.
- Latency W1C write->avl_irq low: 2 clocks, if no other enabled pending bit remains.
- No wait-states; waitrequest is not provided.

Test Plan:
1. Reset then idle, N_IN=6, DEBOUNCE_CYCLES=4, all inputs 0 -> all reads 0, avl_irq=0; RISE_EN/FALL_EN read 0x3F.
2. IRQ_MASK=0x3F, in_sig[2] 0->1 held -> DATA=0x04 and PENDING=0x04 after 2+4 clocks, avl_irq=1 one clock later. Read PENDING twice -> 0x04 both times. Write PENDING=0x04 -> PENDING=0, avl_irq=0 two clocks after the write.
3. Bounce: in_sig[0] pulses high for 3 clocks, low 1, high 3 -> DATA stays 0, PENDING stays 0. Then high for 4+ clocks -> DATA bit0=1, PENDING bit0=1.
4. RISE_EN=0, FALL_EN=0x02; toggle in_sig[1] 0->1->0, each level held 10 clocks -> PENDING=0x02 only after the falling edge; in_sig[3] edges set nothing.
5. IRQ_MASK=0, generate an edge on bit5 -> PENDING=0x20, avl_irq=0. Write IRQ_MASK=0x20 -> avl_irq=1 on the next clock.
6. W1C of bit4 in the same cycle bit4 debounces high -> PENDING bit4=1 (set wins). Assert reset_n=0 mid-count on another channel -> all registers return to reset values and no edge is reported.
